// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// A controller FSM drives load, clear and shift/select strobes into a small accumulator datapath.
module shift_add_mult4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] in_1,
  input  logic [3:0] in_2,
  output logic [7:0] out,
  output logic       ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_r;
  logic [3:0] a_r;
  logic [3:0] q_r;
  logic [4:0] acc_r;
  logic [2:0] cnt_r;

  logic       sig_rst_s;
  logic       ld1_s;
  logic       ld2_s;
  logic       s0_s;
  logic       s1_s;
  logic       s2_s;
  logic [4:0] sum_s;
  logic       last_iter_s;

  assign last_iter_s = (cnt_r == 3'd3);

  // Controller strobes: load/clear on accepted start, add-select and shift in CALC, result load in DONE.
  always_comb begin
    sig_rst_s = 1'b0;
    ld1_s     = 1'b0;
    ld2_s     = 1'b0;
    s0_s      = 1'b0;
    s1_s      = 1'b0;
    s2_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          sig_rst_s = 1'b1;
          ld1_s     = 1'b1;
          ld2_s     = 1'b1;
        end else begin
          sig_rst_s = 1'b0;
        end
      end
      CALC: begin
        s0_s = q_r[0];
        s1_s = 1'b1;
      end
      DONE: begin
        s2_s = 1'b1;
      end
      default: begin
        sig_rst_s = 1'b0;
      end
    endcase
  end

  // Partial-product add selected by the multiplier's low bit; ACC[4] is always zero after a shift.
  always_comb begin
    sum_s = acc_r;
    if (s0_s) begin
      sum_s = {1'b0, acc_r[3:0]} + {1'b0, a_r};
    end else begin
      sum_s = acc_r;
    end
  end

  // Controller state and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ready   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= CALC;
            ready   <= 1'b0;
          end
        end
        CALC: begin
          if (last_iter_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          ready   <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: operand loads, {ACC,Q} right shift with iteration count, and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= 4'd0;
      q_r   <= 4'd0;
      acc_r <= 5'd0;
      cnt_r <= 3'd0;
      out   <= 8'h00;
    end else begin
      if (ld1_s) begin
        a_r <= in_1;
      end
      if (ld2_s) begin
        q_r <= in_2;
      end else if (s1_s) begin
        q_r <= {sum_s[0], q_r[3:1]};
      end
      if (sig_rst_s) begin
        acc_r <= 5'd0;
        cnt_r <= 3'd0;
      end else if (s1_s) begin
        acc_r <= {1'b0, sum_s[4:1]};
        cnt_r <= cnt_r + 3'd1;
      end
      if (s2_s) begin
        out <= {acc_r[3:0], q_r};
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4: directed corners plus random operands,
// compared against a plain-arithmetic product and a fixed five-cycle busy window.
module tb_shift_add_mult4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] in_1;
  logic [3:0] in_2;
  logic [7:0] out;
  logic       ready;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_out;

  always #5 clk = ~clk;

  shift_add_mult4 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_1  (in_1),
    .in_2  (in_2),
    .out   (out),
    .ready (ready)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One multiply from IDLE; poke = start pulse plus operand change mid-CALC,
  // keep = leave start high on return so the next call starts immediately.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit poke, input bit keep);
    logic [7:0] exp_p;
    exp_p = {4'd0, a} * {4'd0, b};
    check("pre_ready", {7'd0, ready}, 8'h01);
    in_1  = a;
    in_2  = b;
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
    check("busy_ready", {7'd0, ready}, 8'h00);
    check("busy_out_hold", out, last_out);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("busy_ready", {7'd0, ready}, 8'h00);
      check("busy_out_hold", out, last_out);
      if (poke && i == 1) begin
        start = 1'b1;
        in_1  = 4'($urandom);
        in_2  = 4'($urandom);
      end
      if (poke && i == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    check("done_ready", {7'd0, ready}, 8'h01);
    check("product", out, exp_p);
    last_out = exp_p;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clk);
    #1;
    check("gap_ready", {7'd0, ready}, 8'h01);
    check("gap_out_hold", out, last_out);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    in_1  = 4'd5;
    in_2  = 4'd5;
    last_out = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("reset_out", out, 8'h00);
    check("reset_ready", {7'd0, ready}, 8'h01);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("no_op_after_reset", {7'd0, ready}, 8'h01);
    check("no_op_out", out, 8'h00);

    run_op(4'd6, 4'd9, 1'b0, 1'b0);
    idle_gap(14);
    run_op(4'd10, 4'd3, 1'b0, 1'b0);
    idle_gap(14);
    run_op(4'd11, 4'd5, 1'b0, 1'b0);
    idle_gap(14);
    run_op(4'd7, 4'd12, 1'b0, 1'b0);

    run_op(4'd0, 4'd13, 1'b0, 1'b0);
    idle_gap(3);
    run_op(4'd15, 4'd15, 1'b0, 1'b0);
    idle_gap(3);
    run_op(4'd1, 4'd15, 1'b0, 1'b0);
    idle_gap(3);

    run_op(4'd9, 4'd7, 1'b1, 1'b0);
    idle_gap(2);

    run_op(4'd3, 4'd4, 1'b0, 1'b1);
    run_op(4'd13, 4'd11, 1'b0, 1'b0);
    idle_gap(2);

    // Reset two cycles into CALC aborts the operation.
    in_1  = 4'd14;
    in_2  = 4'd14;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out", out, 8'h00);
    check("abort_ready", {7'd0, ready}, 8'h01);
    last_out = 8'h00;
    idle_gap(3);
    run_op(4'd12, 4'd12, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      idle_gap(int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
